// File: rtl/decode_pipe.sv
// decode_pipe: decode stage between IF/ID and EX.
// Holds the architectural register file and reads Rs/Rt operands. Detects
// load-use hazards and inserts one bubble for each. Registers the ID/EX word
// with valid/ready handshakes on both sides, and supports a flush.
// Optional build macro DECODE_WB_BYPASS_EN: a writeback to a register that is
// read in the same cycle is forwarded (write-first) instead of stalling.
module decode_pipe #(
  parameter  int DATA_W   = 16,
  parameter  int NUM_REGS = 8,
  parameter  int CTRL_W   = 24,
  localparam int RSEL_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [15:0]       if_instr,
  input  logic [DATA_W-1:0] if_pc_inc,
  input  logic [CTRL_W-1:0] if_ctrl,
  input  logic              if_rs_used,
  input  logic              if_rt_used,
  input  logic [RSEL_W-1:0] if_rd,
  input  logic              if_rd_wr,
  input  logic              if_is_load,
  input  logic              flush,
  input  logic              wb_en,
  input  logic [RSEL_W-1:0] wb_reg,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              ex_ready,
  output logic              id_valid,
  output logic [CTRL_W-1:0] id_ctrl,
  output logic [DATA_W-1:0] id_r1,
  output logic [DATA_W-1:0] id_r2,
  output logic [15:0]       id_instr,
  output logic [DATA_W-1:0] id_pc_inc,
  output logic [RSEL_W-1:0] id_rd,
  output logic              id_rd_wr,
  output logic              id_is_load,
  output logic              err
);

  logic [DATA_W-1:0] rf [NUM_REGS];
  logic [RSEL_W-1:0] rs_sel;
  logic [RSEL_W-1:0] rt_sel;
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;
  logic              wb_in_range;
  logic              wb_ok;
  logic              hazard;
  logic              wbhaz;
  logic              advance;
  logic              accept;

  assign rs_sel = RSEL_W'(if_instr[10:8]);
  assign rt_sel = RSEL_W'(if_instr[7:5]);

  // A select beyond the last register can only occur for non-power-of-two sizes.
  assign wb_in_range = ({1'b0, wb_reg} < (RSEL_W + 1)'(NUM_REGS));
  assign wb_ok       = wb_en & wb_in_range;

  assign hazard  = id_valid & id_is_load & id_rd_wr &
                   ((if_rs_used & (rs_sel == id_rd)) | (if_rt_used & (rt_sel == id_rd)));
  assign advance = ~id_valid | ex_ready;
  assign if_ready = advance & ~hazard & ~wbhaz;
  assign accept  = if_valid & if_ready & ~flush;

`ifdef DECODE_WB_BYPASS_EN
  assign wbhaz = 1'b0;

  // Operand read with write-first forwarding of a same-cycle writeback.
  always_comb begin
    rs_val = rf[rs_sel];
    rt_val = rf[rt_sel];
    if (wb_ok && (wb_reg == rs_sel)) rs_val = wb_data;
    if (wb_ok && (wb_reg == rt_sel)) rt_val = wb_data;
  end
`else
  // Without forwarding, a read that collides with a writeback waits one cycle.
  assign wbhaz = wb_en & ((if_rs_used & (rs_sel == wb_reg)) | (if_rt_used & (rt_sel == wb_reg)));

  // Operand read straight from the stored register values.
  always_comb begin
    rs_val = rf[rs_sel];
    rt_val = rf[rt_sel];
  end
`endif

  // Register file write port; R0 is an ordinary register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
    end else if (wb_ok) begin
      rf[wb_reg] <= wb_data;
    end
  end

  // Flag an out-of-range writeback one cycle after it is presented.
  always_ff @(posedge clk) begin
    if (rst) err <= 1'b0;
    else     err <= wb_en & ~wb_in_range;
  end

  // ID/EX register: flush squashes, advance loads an instruction or a bubble, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      id_valid   <= 1'b0;
      id_ctrl    <= '0;
      id_r1      <= '0;
      id_r2      <= '0;
      id_instr   <= '0;
      id_pc_inc  <= '0;
      id_rd      <= '0;
      id_rd_wr   <= 1'b0;
      id_is_load <= 1'b0;
    end else if (flush) begin
      id_valid   <= 1'b0;
      id_rd_wr   <= 1'b0;
      id_is_load <= 1'b0;
    end else if (advance) begin
      if (accept) begin
        id_valid   <= 1'b1;
        id_ctrl    <= if_ctrl;
        id_r1      <= rs_val;
        id_r2      <= rt_val;
        id_instr   <= if_instr;
        id_pc_inc  <= if_pc_inc;
        id_rd      <= if_rd;
        id_rd_wr   <= if_rd_wr;
        id_is_load <= if_is_load;
      end else begin
        id_valid   <= 1'b0;
        id_rd_wr   <= 1'b0;
        id_is_load <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_decode_pipe.sv
// Testbench for decode_pipe: directed scenarios followed by random traffic,
// all checked against a behavioural model of the decode stage.
module tb_decode_pipe;
  localparam int DW = 16;
  localparam int NR = 8;
  localparam int CW = 24;
  localparam int RW = 3;

  logic          clk = 1'b0;
  logic          rst, if_valid, if_ready, if_rs_used, if_rt_used, if_rd_wr, if_is_load;
  logic [15:0]   if_instr;
  logic [DW-1:0] if_pc_inc;
  logic [CW-1:0] if_ctrl;
  logic [RW-1:0] if_rd, wb_reg, id_rd;
  logic          flush, wb_en, ex_ready, id_valid, id_rd_wr, id_is_load, err;
  logic [DW-1:0] wb_data, id_r1, id_r2, id_pc_inc;
  logic [CW-1:0] id_ctrl;
  logic [15:0]   id_instr;

  always #5 clk = ~clk;

  decode_pipe #(.DATA_W(DW), .NUM_REGS(NR), .CTRL_W(CW)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr),
    .if_pc_inc(if_pc_inc), .if_ctrl(if_ctrl), .if_rs_used(if_rs_used), .if_rt_used(if_rt_used),
    .if_rd(if_rd), .if_rd_wr(if_rd_wr), .if_is_load(if_is_load), .flush(flush),
    .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data), .ex_ready(ex_ready),
    .id_valid(id_valid), .id_ctrl(id_ctrl), .id_r1(id_r1), .id_r2(id_r2), .id_instr(id_instr),
    .id_pc_inc(id_pc_inc), .id_rd(id_rd), .id_rd_wr(id_rd_wr), .id_is_load(id_is_load), .err(err)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Behavioural model of the ID/EX contents and the register file.
  bit            m_valid, m_rd_wr, m_is_load, m_err;
  int unsigned   m_ctrl, m_r1, m_r2, m_instr, m_pc, m_rd;
  int unsigned   m_regs [NR];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned model_read(int unsigned sel);
    int unsigned v = m_regs[sel];
`ifdef DECODE_WB_BYPASS_EN
    if (wb_en && wb_reg == sel) v = wb_data;
`endif
    return v;
  endfunction

  // One clock: check if_ready, advance the model, then check every output.
  task automatic step();
    int unsigned rs, rt, n_r1, n_r2;
    bit hz, wbh, adv, rdy, acc;
    #1;
    rs  = if_instr[10:8];
    rt  = if_instr[7:5];
    hz  = m_valid && m_is_load && m_rd_wr &&
          ((if_rs_used && rs == m_rd) || (if_rt_used && rt == m_rd));
`ifdef DECODE_WB_BYPASS_EN
    wbh = 1'b0;
`else
    wbh = wb_en && ((if_rs_used && rs == wb_reg) || (if_rt_used && rt == wb_reg));
`endif
    adv = !m_valid || ex_ready;
    rdy = adv && !hz && !wbh;
    acc = if_valid && rdy && !flush;
    if (!flush) chk("if_ready", if_ready, rdy);
    n_r1 = model_read(rs);
    n_r2 = model_read(rt);
    @(posedge clk);
    #1;
    if (rst) begin
      m_valid = 0; m_rd_wr = 0; m_is_load = 0; m_err = 0;
      m_ctrl = 0; m_r1 = 0; m_r2 = 0; m_instr = 0; m_pc = 0; m_rd = 0;
      foreach (m_regs[i]) m_regs[i] = 0;
    end else begin
      m_err = wb_en && (wb_reg >= NR);
      if (wb_en && wb_reg < NR) m_regs[wb_reg] = wb_data;
      if (flush) begin
        m_valid = 0; m_rd_wr = 0; m_is_load = 0;
      end else if (adv) begin
        if (acc) begin
          m_valid = 1; m_ctrl = if_ctrl; m_r1 = n_r1; m_r2 = n_r2; m_instr = if_instr;
          m_pc = if_pc_inc; m_rd = if_rd; m_rd_wr = if_rd_wr; m_is_load = if_is_load;
        end else begin
          m_valid = 0; m_rd_wr = 0; m_is_load = 0;
        end
      end
    end
    chk("id_valid", id_valid, m_valid);
    chk("id_ctrl", id_ctrl, m_ctrl);
    chk("id_r1", id_r1, m_r1);
    chk("id_r2", id_r2, m_r2);
    chk("id_instr", id_instr, m_instr);
    chk("id_pc_inc", id_pc_inc, m_pc);
    chk("id_rd", id_rd, m_rd);
    chk("id_rd_wr", id_rd_wr, m_rd_wr);
    chk("id_is_load", id_is_load, m_is_load);
    chk("err", err, m_err);
  endtask

  task automatic idle();
    rst = 0; if_valid = 0; if_instr = 0; if_pc_inc = 0; if_ctrl = 0;
    if_rs_used = 0; if_rt_used = 0; if_rd = 0; if_rd_wr = 0; if_is_load = 0;
    flush = 0; wb_en = 0; wb_reg = 0; wb_data = 0; ex_ready = 1;
  endtask

  task automatic instr(input int rs, input int rt, input bit rs_u, input bit rt_u,
                       input int rd, input bit rd_wr, input bit ld, input int tag);
    if_valid   = 1;
    if_instr   = 16'((tag << 11) | (rs << 8) | (rt << 5) | (tag & 31));
    if_pc_inc  = 16'(tag * 2 + 2);
    if_ctrl    = 24'(tag * 24'h010101);
    if_rs_used = rs_u; if_rt_used = rt_u;
    if_rd = 3'(rd); if_rd_wr = rd_wr; if_is_load = ld;
  endtask

  initial begin
    idle();
    m_valid = 0; m_rd_wr = 0; m_is_load = 0; m_err = 0;
    m_ctrl = 0; m_r1 = 0; m_r2 = 0; m_instr = 0; m_pc = 0; m_rd = 0;
    foreach (m_regs[i]) m_regs[i] = 0;

    // Reset state.
    rst = 1; step(); step(); rst = 0;
    chk("rst_id_valid", id_valid, 1'b0);
    chk("rst_err", err, 1'b0);

    // Write R3, then read Rs=3 / Rt=0.
    wb_en = 1; wb_reg = 3; wb_data = 16'h1234; step(); idle();
    instr(3, 0, 1, 1, 1, 1, 0, 1); step(); idle();
    chk("rd_r3_valid", id_valid, 1'b1);
    chk("rd_r3_r1", id_r1, 16'h1234);
    chk("rd_r3_r2", id_r2, 16'h0000);

    // Load rd=2 followed by a user of Rt=2: one bubble, then accepted.
    instr(1, 0, 0, 0, 2, 1, 1, 2); step();
    instr(0, 2, 0, 1, 4, 1, 0, 3);
    #1 chk("lu_stall_ready", if_ready, 1'b0);
    step();
    chk("lu_bubble", id_valid, 1'b0);
    #1 chk("lu_accept_ready", if_ready, 1'b1);
    step(); idle();
    chk("lu_accept_valid", id_valid, 1'b1);

    // Same pattern but Rt not used: no stall.
    instr(1, 0, 0, 0, 2, 1, 1, 4); step();
    instr(0, 2, 0, 0, 4, 1, 0, 5);
    #1 chk("lu_unused_ready", if_ready, 1'b1);
    step(); idle();

    // EX backpressure for three cycles, then release.
    instr(6, 7, 1, 1, 5, 1, 0, 6); step();
    instr(1, 1, 1, 1, 1, 1, 0, 7); ex_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_ready", if_ready, 1'b0);
      step();
    end
    ex_ready = 1; step(); idle();
    chk("bp_release_instr", id_instr[4:0], 5'd7);

    // Flush with a valid ID/EX word and a valid IF/ID word.
    instr(2, 3, 1, 1, 3, 1, 0, 8); step();
    instr(4, 4, 1, 1, 4, 1, 0, 9); flush = 1; step(); idle();
    chk("flush_valid", id_valid, 1'b0);
    chk("flush_not_consumed", id_instr[4:0], 5'd8);

    // Writeback to R5 colliding with a read of R5.
    step();
    wb_en = 1; wb_reg = 5; wb_data = 16'hBEEF;
    instr(5, 0, 1, 0, 1, 1, 0, 10);
`ifdef DECODE_WB_BYPASS_EN
    #1 chk("wb_bypass_ready", if_ready, 1'b1);
    step(); idle();
`else
    #1 chk("wb_stall_ready", if_ready, 1'b0);
    step(); wb_en = 0;
    step(); idle();
`endif
    chk("wb_r1", id_r1, 16'hBEEF);
    chk("wb_valid", id_valid, 1'b1);

    // Reset in the middle of a stall.
    instr(1, 0, 0, 0, 2, 1, 1, 11); step();
    instr(0, 2, 0, 1, 4, 1, 0, 12); ex_ready = 0; step();
    rst = 1; step(); rst = 0;
    chk("rst_mid_valid", id_valid, 1'b0);
    #1 chk("rst_mid_ready", if_ready, 1'b1);
    step(); idle();

    // Random traffic against the model.
    for (int c = 0; c < 600; c++) begin
      rst        = ($urandom_range(0, 99) == 0);
      if_valid   = ($urandom_range(0, 3) != 0);
      if_instr   = 16'($urandom);
      if_pc_inc  = 16'($urandom);
      if_ctrl    = 24'($urandom);
      if_rs_used = $urandom_range(0, 1);
      if_rt_used = $urandom_range(0, 1);
      if_rd      = 3'($urandom_range(0, 7));
      if_rd_wr   = ($urandom_range(0, 3) != 0);
      if_is_load = $urandom_range(0, 1);
      flush      = ($urandom_range(0, 9) == 0);
      ex_ready   = ($urandom_range(0, 3) != 0);
      wb_en      = ($urandom_range(0, 2) == 0);
      wb_reg     = 3'($urandom_range(0, 7));
      wb_data    = 16'($urandom);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/decode_pipe.md
Name: decode_pipe

Overview:
- Next-generation decode stage for the pipelined core: parametrised register file, valid/ready handshakes on both sides, load-use hazard detection with bubble insertion, flush support, and a registered ID/EX output.
- Sits between the fetch stage (IF/ID) and the execute stage.
- Consumes the instruction plus a pre-decoded control word from the existing control decoder. Produces register operands and pass-through fields one cycle later.

Parameters:
- DATA_W, 16, register and operand width.
- NUM_REGS, 8, architectural register count; select width is RSEL_W = clog2(NUM_REGS), 3 at default.
- CTRL_W, 24, width of the opaque control word carried to EX.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- if_valid  in  1  IF/ID holds a valid instruction.
- if_ready  out  1  decode accepts the IF/ID word this cycle.
- if_instr  in  16  instruction; Rs=[10:8], Rt=[7:5].
- if_pc_inc  in  DATA_W  PC+2 of the instruction.
- if_ctrl  in  CTRL_W  pre-decoded control word.
- if_rs_used  in  1  instruction reads Rs.
- if_rt_used  in  1  instruction reads Rt.
- if_rd  in  RSEL_W  destination register.
- if_rd_wr  in  1  instruction writes a register.
- if_is_load  in  1  instruction is a memory load.
- flush  in  1  squash the IF/ID input and the ID/EX contents (taken branch/jump).
- wb_en  in  1  writeback enable.
- wb_reg  in  RSEL_W  writeback register.
- wb_data  in  DATA_W  writeback data.
- ex_ready  in  1  EX accepts the ID/EX word.
- id_valid  out  1  ID/EX holds a valid instruction.
- id_ctrl  out  CTRL_W  registered control word.
- id_r1  out  DATA_W  registered Rs value.
- id_r2  out  DATA_W  registered Rt value.
- id_instr  out  16  registered instruction.
- id_pc_inc  out  DATA_W  registered PC+2.
- id_rd  out  RSEL_W  registered destination.
- id_rd_wr  out  1  registered write flag.
- id_is_load  out  1  registered load flag.
- err  out  1  registered error flag.

Behaviour:
- Reset: all registers cleared to 0, including every ID/EX field and err.
- Consequently id_valid=0, id_rd_wr=0 and id_is_load=0 out of reset.
- Latency: 1 cycle from IF/ID acceptance to id_valid=1.
- ID/EX advance: advance = ~id_valid | ex_ready.
- hazard (load-use) = id_valid & id_is_load & id_rd_wr & ((if_rs_used & if_instr[10:8]==id_rd) | (if_rt_used & if_instr[7:5]==id_rd)).
- if_ready = advance & ~hazard.
- On advance:
  - IF/ID accepted (if_valid & if_ready & ~flush): ID/EX loads the new instruction; id_valid=1.
  - Otherwise: ID/EX loads a bubble (id_valid=0, id_rd_wr=0, id_is_load=0; data fields are don't-care but held).
- No advance: ID/EX holds all fields unchanged.
- Hazard inserts exactly one bubble. Next cycle the load has moved on, and the dependent instruction is accepted; MEM-stage forwarding is outside this block.
- Flush has priority over everything:
  - Next cycle id_valid=0, regardless of ex_ready.
  - if_ready is don't-care during flush; no IF/ID word is consumed.
- Register file:
  - NUM_REGS x DATA_W, written at the clock edge when wb_en=1.
  - All entries reset to 0.
  - Writes to any register, including R0, are stored; there is no hardwired zero.
- err: registered; set the cycle after wb_en=1 with wb_reg >= NUM_REGS (write ignored), else 0. It is never set at power-of-two NUM_REGS.
- Simultaneous writeback and read of the same register: governed by the optional feature below.
- Reset asserted mid-stall or mid-flush: the reset state wins; no pending bubble or stall persists.

Optional Feature:
- Macro: DECODE_WB_BYPASS_EN.
- Defined: a read whose select matches wb_reg while wb_en=1 returns wb_data in the same cycle (write-first). The wb conflict never stalls.
- Undefined:
  - Reads return the stored value.
  - Add wbhaz = wb_en & ((if_rs_used & if_instr[10:8]==wb_reg) | (if_rt_used & if_instr[7:5]==wb_reg)) to the stall term: if_ready = advance & ~hazard & ~wbhaz.
  - Stall exactly one cycle, then read the updated value.

Test Plan:
- Reset, then write R3=0x1234 via wb; issue an instruction reading Rs=3, Rt=0 with ex_ready=1 -> the next cycle id_valid=1, id_r1=0x1234, id_r2=0x0000.
- A load with rd=2 in ID/EX (id_valid=1, ex_ready=1), IF/ID instruction with Rt=2 and if_rt_used=1 -> if_ready=0 for one cycle, a bubble follows, then the instruction is accepted with if_ready=1.
- Same as the previous case but if_rt_used=0 (Rt field=2) -> no stall; if_ready=1.
- ex_ready=0 for 3 cycles with a valid ID/EX word -> all id_* fields stable and if_ready=0; ex_ready=1 -> advance.
- flush=1 with if_valid=1 and a valid ID/EX word -> id_valid=0 the next cycle; the instruction is not consumed.
- wb_en=1, wb_reg=5, wb_data=0xBEEF with a same-cycle read of R5:
  - With DECODE_WB_BYPASS_EN: id_r1=0xBEEF after 1 cycle, no stall.
  - Without it: 1 stall cycle, then id_r1=0xBEEF.
